// File: rtl/deck_pkg.sv
// Shared constants, FSM state type and card-value mapping for the deck shuffler.
// Pure declarations; no timing of its own.
// No flow control; consumers decide when values are used.
package deck_pkg;

  localparam int         DECK_SIZE         = 52;
  localparam int         RANKS             = 13;
  localparam logic [7:0] ACE_VALUE         = 8'd11;
  localparam logic [7:0] FACE_VALUE        = 8'd10;
  localparam logic [15:0] LFSR_POLY         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  localparam logic [5:0] NO_CARD_ID        = 6'h3F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_SHUF  = 2'd2,
    ST_READY = 2'd3
  } state_e;

  // Card code is suit*13 + rank-1; aces count 11, court cards 10.
  function automatic logic [7:0] code_to_value(input logic [5:0] code);
    logic [3:0] rank;
    logic [7:0] result;
    rank = 4'(code % 6'(RANKS)) + 4'd1;
    if (rank == 4'd1) begin
      result = ACE_VALUE;
    end else if (rank > 4'd10) begin
      result = FACE_VALUE;
    end else begin
      result = {4'd0, rank};
    end
    return result;
  endfunction

endpackage

// File: rtl/deck_lfsr.sv
// Galois LFSR supplying shuffle draws; loads a seed (zero replaced by default seed).
// Load or advance takes effect on the next clock edge.
// No backpressure; advances only when adv is high, load has priority.
module deck_lfsr
  import deck_pkg::*;
#(
  parameter int SEED_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [SEED_W-1:0] seed,
  input  logic              adv,
  output logic [SEED_W-1:0] lfsr
);

  logic [SEED_W-1:0] lfsr_d;
  logic [SEED_W-1:0] lfsr_q;

  // Next LFSR value: seed load wins over a right-shift Galois step.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (seed == '0) ? SEED_W'(LFSR_DEFAULT_SEED) : seed;
    end else if (adv) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? SEED_W'(LFSR_POLY) : '0);
    end
  end

  // LFSR state register; a zero state would lock up, so reset to the default seed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= SEED_W'(LFSR_DEFAULT_SEED);
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/deck_shuffler.sv
// Builds a 52-card deck, Fisher-Yates shuffles it (when DECK_SHUFFLE_EN is defined), serves card values.
// Read port: 1-cycle registered latency; shuffle_ok at least 53 (identity) / 104 (shuffled) cycles after request.
// No backpressure; the consumer must wait for shuffle_ok, a new mix_cards rise restarts at any time.
module deck_shuffler
  import deck_pkg::*;
#(
  parameter int SEED_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mix_cards,
  input  logic [SEED_W-1:0] seed,
  input  logic [5:0]        card_ctrl,
  output logic [7:0]        card,
  output logic [5:0]        card_id,
  output logic              shuffle_ok,
  output logic              busy
);

  state_e      state_d, state_q;
  logic        mix_cards_d, mix_cards_q;
  // Write pointer during INIT, Fisher-Yates position i during SHUF.
  logic [5:0]  idx_d, idx_q;
  logic [5:0]  deck_d [DECK_SIZE];
  logic [5:0]  deck_q [DECK_SIZE];
  logic [7:0]  card_d, card_q;
  logic [5:0]  card_id_d, card_id_q;
  logic        mix_rise;
  logic        lfsr_load;
  logic        lfsr_adv;
  logic [SEED_W-1:0] lfsr;
  logic        unused_lfsr_bits;

  deck_lfsr #(
    .SEED_W(SEED_W)
  ) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .load (lfsr_load),
    .seed (seed),
    .adv  (lfsr_adv),
    .lfsr (lfsr)
  );

  assign mix_cards_d = mix_cards;
  assign mix_rise    = mix_cards & ~mix_cards_q;

`ifdef DECK_SHUFFLE_EN
  logic [5:0] draw;
  assign draw             = lfsr[5:0];
  assign unused_lfsr_bits = ^lfsr[SEED_W-1:6];
`else
  assign unused_lfsr_bits = ^lfsr;
`endif

  // Sequencer: a request rise restarts from INIT in any state; INIT fills, SHUF permutes.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    deck_d    = deck_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    if (mix_rise) begin
      state_d   = ST_INIT;
      idx_d     = '0;
      lfsr_load = 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          deck_d[idx_q] = idx_q;
          if (idx_q == 6'(DECK_SIZE - 1)) begin
`ifdef DECK_SHUFFLE_EN
            state_d = ST_SHUF;
            idx_d   = 6'(DECK_SIZE - 1);
`else
            state_d = ST_READY;
`endif
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
`ifdef DECK_SHUFFLE_EN
        ST_SHUF: begin
          // Draws above i are rejected rather than reduced, keeping the permutation unbiased.
          lfsr_adv = 1'b1;
          if (draw <= idx_q) begin
            deck_d[idx_q] = deck_q[draw];
            deck_d[draw]  = deck_q[idx_q];
            if (idx_q == 6'd1) begin
              state_d = ST_READY;
            end else begin
              idx_d = idx_q - 6'd1;
            end
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

  // Read port: look up the current deck contents, blanking out-of-range indices.
  always_comb begin
    card_d    = '0;
    card_id_d = NO_CARD_ID;
    if (card_ctrl < 6'(DECK_SIZE)) begin
      card_id_d = deck_q[card_ctrl];
      card_d    = code_to_value(deck_q[card_ctrl]);
    end
  end

  // State, deck and read-port registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mix_cards_q <= 1'b0;
      idx_q       <= '0;
      card_q      <= '0;
      card_id_q   <= NO_CARD_ID;
      for (int k = 0; k < DECK_SIZE; k++) begin
        deck_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      mix_cards_q <= mix_cards_d;
      idx_q       <= idx_d;
      card_q      <= card_d;
      card_id_q   <= card_id_d;
      deck_q      <= deck_d;
    end
  end

  assign card       = card_q;
  assign card_id    = card_id_q;
  assign shuffle_ok = (state_q == ST_READY);
  assign busy       = (state_q == ST_INIT) || (state_q == ST_SHUF);

endmodule
